host_mgmt_responder: RTL and testbench
======================================

Name: host_mgmt_responder

Overview:
- Management-side responder for the 10G MAC host bus: the end that `mdio_host_interface` drives.
- Holds the MAC configuration registers: Receiver Config Word 1 (0x240), Transmitter Config (0x280), Management Config (0x340).
- Executes MIIM requests as Clause-45 MDIO frames on the MDC/MDIO pins and returns read data with a `host_miim_rdy` handshake.
- Sits between the host-bus driver and the PHY, entirely in the 50 MHz host domain.

Parameters:
- `PREAMBLE_BITS`, 32, number of preamble ones sent before ST.
- `DIV_MIN`, 1, minimum effective clock-divide value; smaller programmed values are clamped up to it.

Ports:
- `host_clk`  in  1  50 MHz host clock
- `host_reset_n`  in  1  asynchronous reset, active-low
- `host_opcode`  in  2  config: bit1 = 0 write / 1 read; MIIM: 00 address, 01 write, 11 read, 10 read-post-increment
- `host_addr`  in  10  config register address; MIIM: {PRTAD[4:0], DEVAD[4:0]}
- `host_wr_data`  in  32  config write data; MIIM uses [15:0]
- `host_rd_data`  out  32  read return data
- `host_miim_sel`  in  1  0 = config access, 1 = MIIM access
- `host_req`  in  1  MIIM request strobe
- `host_miim_rdy`  out  1  MIIM engine idle / transaction complete
- `rx_cfg_word1`  out  32  0x240 contents
- `tx_cfg`  out  32  0x280 contents
- `mdc`  out  1  MDIO clock
- `mdio_o`  out  1  MDIO output data
- `mdio_t`  out  1  MDIO tristate control, 1 = released
- `mdio_i`  in  1  MDIO input data

Behaviour:
- Reset (asynchronous, `host_reset_n` low):
  - All registers 0; `host_rd_data` = 0.
  - `host_miim_rdy` = 1, `mdc` = 0, `mdio_o` = 1, `mdio_t` = 1.
  - FSM in IDLE. Reset mid-frame aborts immediately; no partial result is kept.
- Config write:
  - Taken every cycle that `host_miim_sel` = 0 and `host_opcode[1]` = 0; `host_req` is not required.
  - Address decode: 0x240 → `rx_cfg_word1`; 0x280 → `tx_cfg`; 0x340 → mgmt, storing `host_wr_data[5:0]` (div[4:0], mdio_en[5]).
  - Writes to other addresses are dropped. Register updates on the next edge.
  - Bit 31 of 0x240 and 0x280 (MAC reset) is self-clearing one cycle after it is written.
- Config read:
  - When `host_miim_sel` = 0 and `host_opcode[1]` = 1, `host_rd_data` is registered one cycle later.
  - Mgmt register reads back {26'b0, en, div}; unmapped addresses read 0.
  - Config reads are allowed while an MDIO frame is running.
- MIIM accept:
  - Condition: IDLE, `host_miim_sel` = 1, `host_req` = 1, mdio_en = 1.
  - Latch opcode, address and `wr_data[15:0]`; `host_miim_rdy` goes to 0 on the same edge.
  - If mdio_en = 0 the request is ignored and `host_miim_rdy` stays 1.
  - `host_req` is ignored while `host_miim_rdy` = 0.
- MDC:
  - D = max(div, `DIV_MIN`), sampled at accept.
  - Each bit lasts 2(D+1) `host_clk` cycles: `mdc` low for the first D+1, high for the last D+1.
  - `mdc` is held 0 outside frames.
- Frame, 64 bits, MSB first:
  - 32 preamble ones, ST = 00, OP[1:0], PRTAD[4:0], DEVAD[4:0], TA, DATA[15:0].
  - Bit i starts at cycle 1 + i·2(D+1) after accept; `mdio_o` changes only at bit start, i.e. during `mdc` low.
- Write / address ops:
  - TA = 10, DATA = latched `wr_data`; `mdio_t` = 0 for all 64 bits.
- Read ops (11, 10):
  - `mdio_t` = 0 through DEVAD; `mdio_t` = 1 from the first TA bit to the end.
  - Each DATA bit is sampled from `mdio_i` on the `host_clk` edge where `mdc` rises.
- Completion:
  - At cycle 1 + 64·2(D+1) after accept: `mdc` = 0, `mdio_t` = 1, `mdio_o` = 1, `host_miim_rdy` = 1.
  - For reads, `host_rd_data` = {16'b0, captured[15:0]} on the same edge. Write and address ops leave `host_rd_data` unchanged.
  - With D = 9 this is 1281 cycles.
- FSM states:
  - IDLE → SHIFT on accept.
  - SHIFT, with a 6-bit bit counter and 5-bit phase counter: counter 63 at end of phase → DONE.
  - DONE → IDLE after one cycle, asserting rdy.
- Simultaneous events:
  - A config write to 0x340 during a frame takes effect only for the next frame.
  - A config access and a MIIM accept in the same cycle are impossible (`host_miim_sel` selects one).

Test Plan:
- Config round trip: write 0x240 = 0x3C00_0000, then read → `rx_cfg_word1` = 0x3C00_0000 and `host_rd_data` = 0x3C00_0000 one cycle after the read; read 0x100 → 0.
- Self-clear: write 0x280 = 0x9000_0000 → `tx_cfg` = 0x9000_0000 for one cycle, then 0x1000_0000.
- MIIM write: write 0x340 = 0x29 (D = 9); request op 01, addr 0x0A1, data 0xBEEF → `mdc` period 20 cycles, serial stream = 32 ones, 00 01 00101 00001 10 1011111011101111; `host_miim_rdy` returns at cycle 1281.
- MIIM read: op 11, PHY model drives 0x1234 after TA → `mdio_t` = 1 from bit 46, `host_rd_data` = 0x0000_1234 at rdy rise.
- Disabled / clamp: mgmt = 0x00 → `host_req` ignored, rdy stays 1; mgmt = 0x20 (div 0) → `mdc` period 4 cycles.
- Reset mid-frame: assert `host_reset_n` low at bit 20 → `mdc` = 0, `mdio_t` = 1, rdy = 1 at once; all config registers 0.

Source files
------------

// File: rtl/host_mgmt_responder.sv
// Host-bus management responder: MAC config registers plus a Clause-45 MDIO master.
// Config reads return one cycle later; MIIM frames take 1 + frame_bits*2(D+1) cycles, host_req ignored while busy.
module host_mgmt_responder #(
    parameter int PREAMBLE_BITS = 32,
    parameter int DIV_MIN       = 1
) (
    input  logic        host_clk,
    input  logic        host_reset_n,
    input  logic [1:0]  host_opcode,
    input  logic [9:0]  host_addr,
    input  logic [31:0] host_wr_data,
    output logic [31:0] host_rd_data,
    input  logic        host_miim_sel,
    input  logic        host_req,
    output logic        host_miim_rdy,
    output logic [31:0] rx_cfg_word1,
    output logic [31:0] tx_cfg,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int FRAME_BITS = PREAMBLE_BITS + 32;
    localparam int BW         = $clog2(FRAME_BITS);

    localparam logic [BW-1:0] PRE_END   = BW'(PREAMBLE_BITS);
    localparam logic [BW-1:0] TA_BIT    = BW'(PREAMBLE_BITS + 14);
    localparam logic [BW-1:0] DATA_BIT  = BW'(PREAMBLE_BITS + 16);
    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);
    localparam logic [4:0]    DIV_FLOOR = 5'(DIV_MIN);

    localparam logic [9:0] ADDR_RX_CFG1 = 10'h240;
    localparam logic [9:0] ADDR_TX_CFG  = 10'h280;
    localparam logic [9:0] ADDR_MGMT    = 10'h340;

    logic        cfg_wr;
    logic        cfg_rd;
    logic [31:0] cfg_rd_val;
    logic [4:0]  mgmt_div;
    logic        mgmt_en;

    logic [1:0]    state;
    logic [1:0]    op_q;
    logic [9:0]    addr_q;
    logic [15:0]   data_q;
    logic [4:0]    div_q;
    logic [BW-1:0] bit_cnt;
    logic [4:0]    phase;
    logic          hi_half;
    logic [15:0]   cap_q;

    logic [31:0] tail;
    logic [4:0]  tail_pos;
    logic        tx_bit;
    logic        is_read;
    logic        released;
    logic        accept;

    assign cfg_wr = !host_miim_sel && !host_opcode[1];
    assign cfg_rd = !host_miim_sel &&  host_opcode[1];

    // Bit 31 of the two MAC config words is a reset pulse: cleared the cycle after any write sets it.
    always_ff @(posedge host_clk or negedge host_reset_n) begin
        if (!host_reset_n) begin
            rx_cfg_word1 <= '0;
            tx_cfg       <= '0;
            mgmt_div     <= '0;
            mgmt_en      <= 1'b0;
        end else begin
            rx_cfg_word1[31] <= 1'b0;
            tx_cfg[31]       <= 1'b0;
            if (cfg_wr) begin
                case (host_addr)
                    ADDR_RX_CFG1: rx_cfg_word1 <= host_wr_data;
                    ADDR_TX_CFG:  tx_cfg       <= host_wr_data;
                    ADDR_MGMT: begin
                        mgmt_div <= host_wr_data[4:0];
                        mgmt_en  <= host_wr_data[5];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cfg_rd_val = '0;
        case (host_addr)
            ADDR_RX_CFG1: cfg_rd_val = rx_cfg_word1;
            ADDR_TX_CFG:  cfg_rd_val = tx_cfg;
            ADDR_MGMT:    cfg_rd_val = {26'b0, mgmt_en, mgmt_div};
            default:      cfg_rd_val = '0;
        endcase
    end

    // Everything after the preamble: ST, OP, PRTAD, DEVAD, TA, DATA.
    assign tail     = {2'b00, op_q, addr_q, 2'b10, data_q};
    assign tail_pos = 5'(bit_cnt - PRE_END);
    assign tx_bit   = (bit_cnt < PRE_END) ? 1'b1 : tail[~tail_pos];
    assign is_read  = op_q[1];
    assign released = is_read && (bit_cnt >= TA_BIT);
    assign accept   = (state == ST_IDLE) && host_miim_sel && host_req && mgmt_en;

    always_ff @(posedge host_clk or negedge host_reset_n) begin
        if (!host_reset_n) begin
            state         <= ST_IDLE;
            op_q          <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            div_q         <= '0;
            bit_cnt       <= '0;
            phase         <= '0;
            hi_half       <= 1'b0;
            cap_q         <= '0;
            mdc           <= 1'b0;
            mdio_o        <= 1'b1;
            mdio_t        <= 1'b1;
            host_miim_rdy <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q          <= host_opcode;
                        addr_q        <= host_addr;
                        data_q        <= host_wr_data[15:0];
                        div_q         <= (mgmt_div < DIV_FLOOR) ? DIV_FLOOR : mgmt_div;
                        bit_cnt       <= '0;
                        phase         <= '0;
                        hi_half       <= 1'b0;
                        cap_q         <= '0;
                        host_miim_rdy <= 1'b0;
                        state         <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Data changes only at the start of the low half; the PHY's bit is taken as mdc rises.
                    if (phase == 5'd0) begin
                        if (!hi_half) begin
                            mdc    <= 1'b0;
                            mdio_t <= released;
                            mdio_o <= released ? 1'b1 : tx_bit;
                        end else begin
                            mdc <= 1'b1;
                            if (is_read && (bit_cnt >= DATA_BIT)) begin
                                cap_q <= {cap_q[14:0], mdio_i};
                            end
                        end
                    end
                    if (phase == div_q) begin
                        phase   <= '0;
                        hi_half <= ~hi_half;
                        if (hi_half) begin
                            if (bit_cnt == LAST_BIT) begin
                                state <= ST_DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        phase <= phase + 5'd1;
                    end
                end
                ST_DONE: begin
                    mdc           <= 1'b0;
                    mdio_o        <= 1'b1;
                    mdio_t        <= 1'b1;
                    host_miim_rdy <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A completing MIIM read owns the return bus on its last edge.
    always_ff @(posedge host_clk or negedge host_reset_n) begin
        if (!host_reset_n) begin
            host_rd_data <= '0;
        end else if ((state == ST_DONE) && is_read) begin
            host_rd_data <= {16'b0, cap_q};
        end else if (cfg_rd) begin
            host_rd_data <= cfg_rd_val;
        end
    end

endmodule

// File: tb/tb_host_mgmt_responder.sv
// Bench for host_mgmt_responder: config vector table, directed MIIM sequences and
// randomized MIIM frames checked against a bit-queue model of the MDIO frame.
module tb_host_mgmt_responder;

    logic        host_clk = 1'b0;
    logic        host_reset_n = 1'b0;
    logic [1:0]  host_opcode = 2'b00;
    logic [9:0]  host_addr = '0;
    logic [31:0] host_wr_data = '0;
    logic [31:0] host_rd_data;
    logic        host_miim_sel = 1'b1;
    logic        host_req = 1'b0;
    logic        host_miim_rdy;
    logic [31:0] rx_cfg_word1;
    logic [31:0] tx_cfg;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_t;
    logic        mdio_i = 1'b0;

    host_mgmt_responder #(.PREAMBLE_BITS(32), .DIV_MIN(1)) dut (
        .host_clk      (host_clk),
        .host_reset_n  (host_reset_n),
        .host_opcode   (host_opcode),
        .host_addr     (host_addr),
        .host_wr_data  (host_wr_data),
        .host_rd_data  (host_rd_data),
        .host_miim_sel (host_miim_sel),
        .host_req      (host_req),
        .host_miim_rdy (host_miim_rdy),
        .rx_cfg_word1  (rx_cfg_word1),
        .tx_cfg        (tx_cfg),
        .mdc           (mdc),
        .mdio_o        (mdio_o),
        .mdio_t        (mdio_t),
        .mdio_i        (mdio_i)
    );

    always #10 host_clk = ~host_clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_rd = '0;

    typedef struct {
        logic        sel;
        logic [1:0]  op;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [31:0] e_rx;
        logic [31:0] e_tx;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        host_miim_sel = 1'b1;
        host_req      = 1'b0;
        host_opcode   = 2'b00;
        host_addr     = '0;
        host_wr_data  = '0;
    endtask

    task automatic cfg_write(input logic [9:0] a, input logic [31:0] d);
        host_miim_sel = 1'b0;
        host_opcode   = 2'b00;
        host_addr     = a;
        host_wr_data  = d;
        @(posedge host_clk); #1;
        idle_inputs();
    endtask

    // Drives one MIIM transaction and checks it cycle by cycle against a frame built from the field layout.
    task automatic run_miim(input logic [1:0] op, input logic [9:0] a, input logic [15:0] wd,
                            input logic [4:0] div, input logic [15:0] phy_data,
                            input bit hold_req, input string tag);
        bit frame[$];
        int d, p, bit_i, ph;
        int bad_mdc = 0, bad_o = 0, bad_t = 0, bad_rdy = 0;
        bit is_rd, exp_mdc, exp_t;
        cfg_write(10'h340, {26'b0, 1'b1, div});
        d = (int'(div) < 1) ? 1 : int'(div);
        p = 2 * (d + 1);
        is_rd = op[1];
        for (int i = 0; i < 32; i++) frame.push_back(1'b1);
        frame.push_back(1'b0); frame.push_back(1'b0);
        frame.push_back(op[1]); frame.push_back(op[0]);
        for (int i = 9; i >= 0; i--) frame.push_back(a[i]);
        frame.push_back(1'b1); frame.push_back(1'b0);
        for (int i = 15; i >= 0; i--) frame.push_back(wd[i]);

        host_miim_sel = 1'b1;
        host_req      = 1'b1;
        host_opcode   = op;
        host_addr     = a;
        host_wr_data  = {16'(($urandom)), wd};
        @(posedge host_clk); #1;
        check({tag, " rdy low at accept"}, 32'(host_miim_rdy), 32'd0);
        if (!hold_req) host_req = 1'b0;

        for (int c = 1; c <= 64 * p; c++) begin
            @(posedge host_clk); #1;
            bit_i = (c - 1) / p;
            ph    = (c - 1) % p;
            if (is_rd && bit_i >= 48) mdio_i = phy_data[15 - (bit_i - 48)];
            exp_mdc = (ph >= d + 1);
            exp_t   = is_rd && (bit_i >= 46);
            if (mdc !== exp_mdc) bad_mdc++;
            if (mdio_t !== exp_t) bad_t++;
            if (!exp_t && (mdio_o !== frame[bit_i])) bad_o++;
            if (host_miim_rdy !== 1'b0) bad_rdy++;
        end
        host_req = 1'b0;
        check({tag, " mdc waveform bad cycles"}, 32'(bad_mdc), 32'd0);
        check({tag, " mdio_t bad cycles"}, 32'(bad_t), 32'd0);
        check({tag, " mdio_o bad cycles"}, 32'(bad_o), 32'd0);
        check({tag, " rdy early cycles"}, 32'(bad_rdy), 32'd0);

        @(posedge host_clk); #1;
        if (is_rd) model_rd = {16'b0, phy_data};
        check({tag, " rdy at end"}, 32'(host_miim_rdy), 32'd1);
        check({tag, " end mdc/mdio_t/mdio_o"}, {29'b0, mdc, mdio_t, mdio_o}, 32'b011);
        check({tag, " rd_data"}, host_rd_data, model_rd);
        idle_inputs();
    endtask

    initial begin
        int bad;
        vt[0]  = '{1'b0, 2'b00, 10'h240, 32'h3C00_0000, 32'h3C00_0000, 32'h0,         32'h0};
        vt[1]  = '{1'b0, 2'b10, 10'h240, 32'h0,         32'h3C00_0000, 32'h0,         32'h3C00_0000};
        vt[2]  = '{1'b0, 2'b10, 10'h100, 32'h0,         32'h3C00_0000, 32'h0,         32'h0};
        vt[3]  = '{1'b0, 2'b01, 10'h280, 32'h9000_0000, 32'h3C00_0000, 32'h9000_0000, 32'h0};
        vt[4]  = '{1'b1, 2'b00, 10'h000, 32'h0,         32'h3C00_0000, 32'h1000_0000, 32'h0};
        vt[5]  = '{1'b0, 2'b00, 10'h240, 32'h8000_0005, 32'h8000_0005, 32'h1000_0000, 32'h0};
        vt[6]  = '{1'b1, 2'b00, 10'h000, 32'h0,         32'h0000_0005, 32'h1000_0000, 32'h0};
        vt[7]  = '{1'b0, 2'b00, 10'h300, 32'hFFFF_FFFF, 32'h0000_0005, 32'h1000_0000, 32'h0};
        vt[8]  = '{1'b0, 2'b00, 10'h340, 32'hFFFF_FFE9, 32'h0000_0005, 32'h1000_0000, 32'h0};
        vt[9]  = '{1'b0, 2'b11, 10'h340, 32'h0,         32'h0000_0005, 32'h1000_0000, 32'h0000_0029};
        vt[10] = '{1'b0, 2'b10, 10'h280, 32'h0,         32'h0000_0005, 32'h1000_0000, 32'h1000_0000};
        vt[11] = '{1'b0, 2'b10, 10'h240, 32'h0,         32'h0000_0005, 32'h1000_0000, 32'h0000_0005};

        idle_inputs();
        #25;
        check("reset rdy", 32'(host_miim_rdy), 32'd1);
        check("reset mdc/mdio_t/mdio_o", {29'b0, mdc, mdio_t, mdio_o}, 32'b011);
        check("reset rd_data", host_rd_data, 32'h0);
        check("reset rx_cfg_word1", rx_cfg_word1, 32'h0);
        check("reset tx_cfg", tx_cfg, 32'h0);
        @(negedge host_clk);
        host_reset_n = 1'b1;
        @(posedge host_clk); #1;

        for (int i = 0; i < 12; i++) begin
            host_miim_sel = vt[i].sel;
            host_req      = 1'b0;
            host_opcode   = vt[i].op;
            host_addr     = vt[i].addr;
            host_wr_data  = vt[i].wd;
            @(posedge host_clk); #1;
            check($sformatf("vec%0d rx_cfg_word1", i), rx_cfg_word1, vt[i].e_rx);
            check($sformatf("vec%0d tx_cfg", i), tx_cfg, vt[i].e_tx);
            check($sformatf("vec%0d rd_data", i), host_rd_data, vt[i].e_rd);
        end
        idle_inputs();
        model_rd = 32'h0000_0005;

        run_miim(2'b01, 10'h0A1, 16'hBEEF, 5'd9, 16'h0000, 1'b0, "miim write");
        run_miim(2'b11, 10'h2C3, 16'h0000, 5'd2, 16'h1234, 1'b1, "miim read");
        for (int n = 0; n < 6; n++) begin
            run_miim(2'($urandom_range(0, 3)), 10'($urandom), 16'($urandom),
                     5'($urandom_range(0, 5)), 16'($urandom), 1'($urandom),
                     $sformatf("rand%0d", n));
        end

        // Reset in the middle of a frame, during the mdc-high half of bit 20.
        cfg_write(10'h240, 32'h1234_5678);
        cfg_write(10'h280, 32'h00AB_CDEF);
        cfg_write(10'h340, 32'h0000_0029);
        host_miim_sel = 1'b1; host_req = 1'b1; host_opcode = 2'b01; host_addr = 10'h155;
        @(posedge host_clk); #1;
        host_req = 1'b0;
        repeat (20 * 20 + 15) @(posedge host_clk);
        #1;
        check("pre-reset mdc high", 32'(mdc), 32'd1);
        host_reset_n = 1'b0;
        #1;
        check("midreset rdy", 32'(host_miim_rdy), 32'd1);
        check("midreset mdc/mdio_t/mdio_o", {29'b0, mdc, mdio_t, mdio_o}, 32'b011);
        check("midreset rx_cfg_word1", rx_cfg_word1, 32'h0);
        check("midreset tx_cfg", tx_cfg, 32'h0);
        check("midreset rd_data", host_rd_data, 32'h0);
        @(negedge host_clk);
        host_reset_n = 1'b1;
        model_rd = 32'h0;
        idle_inputs();
        @(posedge host_clk); #1;

        // Management register cleared by reset: MDIO disabled, requests ignored.
        host_miim_sel = 1'b0; host_opcode = 2'b10; host_addr = 10'h340;
        @(posedge host_clk); #1;
        check("mgmt after reset", host_rd_data, 32'h0);
        host_miim_sel = 1'b1; host_req = 1'b1; host_opcode = 2'b01; host_addr = 10'h0A1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge host_clk); #1;
            if (host_miim_rdy !== 1'b1 || mdc !== 1'b0 || mdio_t !== 1'b1) bad++;
        end
        check("disabled req ignored bad cycles", 32'(bad), 32'd0);
        idle_inputs();

        run_miim(2'b00, 10'h3FF, 16'h5A5A, 5'd0, 16'h0000, 1'b0, "clamp div0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
